// File: rtl/fifo_share_pkg.sv
// Shared definitions for the shared-FIFO controller: tag width and FIFO word layout.
package fifo_share_pkg;

  // Requester tag width: clog2(num_req), never less than one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    if (num_req <= 32'd2) return 32'd1;
    return unsigned'($clog2(num_req));
  endfunction

  // FIFO word layout: payload at the LSBs, requester tag directly above it.
  localparam int unsigned PAYLOAD_LSB = 0;

  function automatic int unsigned id_lsb(input int unsigned payload_w);
    return payload_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Ports: req (requests), enable (grant allowed), advance (grant consumed),
//        grant (one-hot, combinational), index (binary grant index).
module rr_arbiter
  import fifo_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);

  logic [ID_W-1:0] ptr;

  // Search from ptr upwards, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    int unsigned c;
    logic        found;
    grant = '0;
    index = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      c = 32'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (enable && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        index    = ID_W'(c);
      end
    end
  end

  // Pointer moves just past the winner only when its word actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (index == ID_W'(NUM_REQ - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags and a one-cycle registered read port.
// Ports: write_en/write_data (push), read_en/read_data (pop, data next cycle),
//        fifo_full/fifo_empty (registered), data_count (current occupancy).
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PTR   = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [PTR:0]     data_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR-1:0]   wr_ptr;
  logic [PTR-1:0]   rd_ptr;
  logic [PTR:0]     count;
  logic [PTR:0]     count_next;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok      = write_en & ~fifo_full;
  assign rd_ok      = read_en & ~fifo_empty;
  assign count_next = count + (PTR+1)'(wr_ok) - (PTR+1)'(rd_ok);
  assign data_count = count;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= write_data;
  end

  // Pointers, count and flags; flags track the post-edge count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_data  <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PTR'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == PTR'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count      <= count_next;
      fifo_full  <= (count_next == (PTR+1)'(DEPTH));
      fifo_empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one sync_fifo among NUM_REQ round-robin writers, tags each word with
// its requester index, and drains through a valid/ready port via a 2-entry buffer.
// Ports: req_valid/req_data/req_ready (per-requester write side, req_ready one-hot),
//        out_valid/out_ready/out_data/out_id (drain side), level (words held).
module fifo_share_ctrl
  import fifo_share_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_PTR   = 10,
  parameter int unsigned FIFO_DEPTH = 1024,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIFO_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [FIFO_PTR+1:0]           level
);

  localparam int unsigned WORD_W = FIFO_WIDTH + ID_W;
  localparam int unsigned LVL_W  = FIFO_PTR + 2;
  localparam int unsigned ID_LSB = id_lsb(FIFO_WIDTH);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_PTR:0]     fifo_count;
  logic                  write_en;
  logic [WORD_W-1:0]     write_data;
  logic                  read_en;
  logic [WORD_W-1:0]     read_data;
  logic [ID_W-1:0]       grant_idx;
  logic [FIFO_WIDTH-1:0] payload;
  logic                  arb_en;
  logic                  inflight;
  logic [1:0]            occ;
  logic [WORD_W-1:0]     buf0;
  logic [WORD_W-1:0]     buf1;
  logic                  pop;

  // arb_en is a flop so no grant can appear while rst_n is low.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .enable  (arb_en & ~fifo_full),
    .advance (write_en),
    .grant   (req_ready),
    .index   (grant_idx)
  );

  // Payload mux for the granted requester.
  always_comb begin
    payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) payload = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign write_en   = |(req_valid & req_ready);
  assign write_data = {grant_idx, payload};

  // Credit check counts the in-flight read so the buffer can never overflow.
  assign pop     = out_valid & out_ready;
  assign read_en = ~fifo_empty & ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);

  sync_fifo #(.WIDTH(WORD_W), .PTR(FIFO_PTR), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .data_count (fifo_count)
  );

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0[PAYLOAD_LSB +: FIFO_WIDTH];
  assign out_id    = buf0[ID_LSB +: ID_W];

  // Output buffer: buf0 is the head; captures land in the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en   <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
      level    <= '0;
    end else begin
      arb_en   <= 1'b1;
      inflight <= read_en;
      case ({pop, inflight})
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= read_data;
          end else begin
            buf0 <= read_data;
          end
        end
        2'b10: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) buf0 <= read_data;
          else             buf1 <= read_data;
          occ <= occ + 2'd1;
        end
        default: ;
      endcase
      // Words held after this edge: FIFO + buffer + in-flight, adjusted for this cycle's moves.
      level <= LVL_W'(fifo_count) + LVL_W'(occ) + LVL_W'(inflight)
             + LVL_W'(write_en) - LVL_W'(pop);
    end
  end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Self-checking bench for fifo_share_ctrl: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_fifo_share_ctrl;

  localparam int NREQ = 4;
  localparam int FW   = 32;
  localparam int FP   = 3;
  localparam int FD   = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*FW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [FW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic [FP+1:0]     level;

  fifo_share_ctrl #(.NUM_REQ(NREQ), .FIFO_WIDTH(FW), .FIFO_PTR(FP), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words held in acceptance order, plus the RR pointer.
  logic [IDW+FW-1:0] sb[$];
  int                rr_ptr = 0;
  int                accepted = 0;
  int                popped = 0;
  logic              prev_stall = 1'b0;
  logic [IDW+FW-1:0] prev_word = '0;

  logic [NREQ-1:0] obs_ready;
  logic            obs_valid;
  logic [FW-1:0]   obs_data;
  logic [IDW-1:0]  obs_id;
  logic [FP+1:0]   obs_level;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] exp_ready;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*FW +: FW] = $urandom();
  endtask

  // One clock cycle: inputs already driven; sample and check at negedge, then cross the edge.
  task automatic step();
    int idx;
    logic [NREQ-1:0] exp_g;
    @(negedge clk);
    obs_ready = req_ready;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_id    = out_id;
    obs_level = level;
    chk("level", 64'(level), 64'(sb.size()));
    idx = pick(req_valid, rr_ptr);
    exp_g = '0;
    if (idx >= 0) exp_g[idx] = 1'b1;
    if (idx < 0)                  chk("grant_idle", 64'(req_ready), 64'd0);
    else if (sb.size() < FD)      chk("grant", 64'(req_ready), 64'(exp_g));
    else if (sb.size() >= FD + 2) chk("grant_full", 64'(req_ready), 64'd0);
    else if (req_ready != '0)     chk("grant_near_full", 64'(req_ready), 64'(exp_g));
    if (prev_stall) begin
      chk("stall_valid_hold", 64'(out_valid), 64'd1);
      chk("stall_word_hold", 64'({out_id, out_data}), 64'(prev_word));
    end
    if (out_valid) begin
      chk("valid_has_word", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("out_word", 64'({out_id, out_data}), 64'(sb[0]));
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      void'(sb.pop_front());
      popped++;
    end
    if (idx >= 0 && (req_valid & req_ready) != '0) begin
      sb.push_back({2'(idx), req_data[idx*FW +: FW]});
      rr_ptr = (idx + 1) % NREQ;
      accepted++;
    end
    prev_stall = out_valid & ~out_ready;
    prev_word  = {out_id, out_data};
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    req_valid = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rr_ptr = 0;
    prev_stall = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, cyc;

    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0100};
    tbl[2]  = '{4'b1111, 4'b1000};
    tbl[3]  = '{4'b1111, 4'b0001};
    tbl[4]  = '{4'b0001, 4'b0001};
    tbl[5]  = '{4'b1010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};
    tbl[7]  = '{4'b0110, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b0011, 4'b0001};
    tbl[10] = '{4'b0011, 4'b0010};
    tbl[11] = '{4'b1100, 4'b0100};

    // Reset and idle
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid", 64'(obs_valid), 64'd0);
    end

    // Grant table starting from pointer 0
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NREQ; i++) req_data[i*FW +: FW] = 32'hC0DE_0000 + 32'(r << 8) + 32'(i);
      req_valid = tbl[r].valid;
      out_ready = 1'b1;
      step();
      chk("tbl_grant", 64'(obs_ready), 64'(tbl[r].exp_ready));
    end
    drain();

    // Single word latency from requester 2
    req_data[2*FW +: FW] = 32'hA5A5_0001;
    req_valid = 4'b0100;
    step();
    chk("lat_accept", 64'(obs_ready), 64'b0100);
    req_valid = '0;
    step();
    chk("lat_t1_valid", 64'(obs_valid), 64'd0);
    chk("lat_t1_level", 64'(obs_level), 64'd1);
    step();
    chk("lat_t2_valid", 64'(obs_valid), 64'd0);
    step();
    chk("lat_t3_valid", 64'(obs_valid), 64'd1);
    chk("lat_t3_data", 64'(obs_data), 64'hA5A5_0001);
    chk("lat_t3_id", 64'(obs_id), 64'd2);
    chk("lat_t3_level", 64'(obs_level), 64'd1);
    step();
    chk("lat_t4_valid", 64'(obs_valid), 64'd0);
    chk("lat_t4_level", 64'(obs_level), 64'd0);

    // All requesters valid: full throughput
    a0 = accepted;
    p0 = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      if (i == 8) p0 = popped;
      step();
    end
    chk("thru_accepted", 64'(accepted - a0), 64'd20);
    chk("thru_popped", 64'(popped - p0), 64'd12);
    drain();

    // Fill to capacity with consumer stalled
    a0 = accepted;
    req_valid = 4'b0001;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step();
    end
    chk("full_accepted", 64'(accepted - a0), 64'd10);
    chk("full_level", 64'(obs_level), 64'd10);
    chk("full_ready", 64'(obs_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
    end
    chk("full_resume", 64'((accepted - a0) > 10), 64'd1);
    drain();

    // Randomized traffic: 3 requesters, 50% consumer stalls
    a0 = accepted;
    cyc = 0;
    while ((accepted - a0) < 2000 && cyc < 20000) begin
      req_valid = {1'b0, 3'($urandom_range(0, 7))};
      rand_data();
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("rand_accepted", 64'((accepted - a0) >= 2000), 64'd1);
    drain();

    // Reset mid-stream at level 5
    req_valid = 4'b0001;
    out_ready = 1'b0;
    for (int i = 0; i < 20 && sb.size() < 5; i++) begin
      rand_data();
      step();
    end
    chk("mid_level_pre", 64'(level), 64'd5);
    reset_dut();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    rand_data();
    step();
    chk("post_rst_level", 64'(obs_level), 64'd0);
    chk("post_rst_grant", 64'(obs_ready), 64'b0001);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_share_ctrl.md
Name: fifo_share_ctrl

Overview:
- Shares one sync_fifo between NUM_REQ write requesters using round-robin arbitration, and drains it through a valid/ready output port.
- Each accepted word is tagged with its requester index, so the DSA-side consumer can demultiplex.
- Hides the one-cycle SRAM read latency behind a 2-entry output buffer, and guarantees the FIFO is never written when full or read when empty.

Parameters:
- NUM_REQ, 4, number of write requesters (2..16).
- FIFO_WIDTH, 32, payload bits per word.
- FIFO_PTR, 10, FIFO address width; FIFO_DEPTH <= 2**FIFO_PTR.
- FIFO_DEPTH, 1024, FIFO entries.
- ID_W (localparam), clog2(NUM_REQ) with minimum 1, requester tag width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  packed payloads; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a word transfers when req_valid[i] & req_ready[i].
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts.
- out_data  out  FIFO_WIDTH  output payload.
- out_id  out  ID_W  requester index of out_data.
- level  out  FIFO_PTR+2  words held: FIFO count + buffer occupancy + in-flight reads.

Behaviour:
- Reset (async, rst_n=0):
  - req_ready=0, out_valid=0, out_data=0, out_id=0, level=0.
  - RR pointer=0; buffer and in-flight flag cleared.
  - The sync_fifo resets with the same rst_n.
- Write arbitration (combinational grant):
  - When fifo_full=0, grant the first valid requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - No valid requester or fifo_full=1: req_ready all zero.
  - req_ready never depends on out_ready.
  - write_en = |(req_valid & req_ready); write_data = {granted index, granted payload}.
  - The FIFO is instantiated with width FIFO_WIDTH+ID_W.
  - On a transfer, the RR pointer becomes granted index + 1 (wrapping from NUM_REQ-1 to 0). With no transfer it holds.
- Full boundary:
  - fifo_full is registered and reflects the current count, so a write is safe whenever fifo_full=0.
  - A write and a read in the same cycle at full are not possible, because the write is blocked.
- Read sequencing:
  - read_en = ~fifo_empty & (occ + inflight - pop < 2), where occ = buffer entries (0..2), inflight = read issued last cycle, and pop = out_valid & out_ready.
  - FIFO read_data is valid the cycle after read_en (inflight=1) and is written into the buffer tail that cycle.
  - The buffer is a 2-entry in-order queue. The head drives out_data/out_id, and out_valid = (occ != 0).
  - Pop and capture in the same cycle are legal; occ is unchanged in that case.
  - The buffer never overflows, because the credit check counts inflight.
- Throughput and latency:
  - Steady state: 1 word/cycle in and out.
  - A word accepted at cycle t into an empty system gives out_valid=1 at cycle t+3 (empty deasserts at t+1, read_en at t+1, capture at t+2).
- Output stability: while out_valid=1 and out_ready=0, out_data and out_id hold.
- Ordering: output order equals acceptance order; no loss, no duplication.
- level:
  - Registered, updated every cycle: fifo_data_count + occ + inflight.
  - Maximum value FIFO_DEPTH+2.
- Reset mid-operation: all contents are discarded immediately. After release, level=0 and the next grant starts from requester 0.

Decomposition:
- Shared package fifo_share_pkg: ID_W computation function; FIFO word layout constants (ID field at the MSBs, payload at the LSBs).
- Sub-module rr_arbiter (NUM_REQ): inputs req, enable, advance; outputs one-hot grant and index. Holds the RR pointer.
- The existing sync_fifo is instantiated directly; the output buffer stays inline.

Test Plan:
1. Reset, no requests, out_ready=1 -> req_ready=0, out_valid=0, level=0 throughout.
2. Requester 2 sends 0xA5A50001 at cycle t -> out_valid=1 at t+3 with out_data=0xA5A50001, out_id=2; level goes 1 then back to 0 after the pop.
3. All 4 requesters always valid, out_ready=1 -> grants 0,1,2,3,0,...; out_id repeats 0,1,2,3; one word per cycle after fill.
4. FIFO_DEPTH=8, FIFO_PTR=3, out_ready=0, requester 0 streams -> 10 words accepted, then req_ready[0]=0 and level=10. Set out_ready=1 -> words 0..9 emerge in order and acceptance resumes.
5. Random out_ready (50%) with 3 random requesters, 2000 words -> scoreboard shows in-order per acceptance, no loss or duplication, and out_data stable while stalled.
6. Assert rst_n low mid-stream with level=5 -> outputs zero asynchronously. After release, level=0, and the first grant with all requesters valid goes to requester 0.
